// File: rtl/recirc_pkg.sv
// Shared types and widths for the recirculation-stage lane scheduler.
package recirc_pkg;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int LANE_W = 2;
    localparam int GCNT_W = 16;
    localparam int RCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/recirc_lane_scheduler_rr_arbiter4.sv
// Four-way round-robin arbiter: first requesting lane at or after rr_ptr wins.
module rr_arbiter4
    import recirc_pkg::*;
(
    input  logic [LANES-1:0]  req,
    input  logic [LANE_W-1:0] rr_ptr,
    output logic [LANES-1:0]  grant,
    output logic [LANE_W-1:0] grant_idx,
    output logic              any_grant
);

    logic [LANE_W-1:0] idx;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = rr_ptr + LANE_W'(k);
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/recirc_lane_scheduler.sv
// Round-robin egress scheduler with stall timeout recirculation.
// Optional STATS_EN macro adds per-lane grant and recirculation counters.
module recirc_lane_scheduler
    import recirc_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LANES-1:0]     req,
    input  logic [DATA_W-1:0]    In0,
    input  logic [DATA_W-1:0]    In1,
    input  logic [DATA_W-1:0]    In2,
    input  logic [DATA_W-1:0]    In3,
    input  logic                 dsReady,
    output logic [LANES-1:0]     pop,
    output logic [DATA_W-1:0]    dataOut,
    output logic                 validOut,
    output logic [LANE_W-1:0]    laneOut,
    output logic [DATA_W-1:0]    recircData,
    output logic                 recircValid,
    output logic                 busy
`ifdef STATS_EN
    ,
    output logic [GCNT_W-1:0]    grantCnt0,
    output logic [GCNT_W-1:0]    grantCnt1,
    output logic [GCNT_W-1:0]    grantCnt2,
    output logic [GCNT_W-1:0]    grantCnt3,
    output logic [RCNT_W-1:0]    recircCnt
`endif
);

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [LANE_W-1:0]  rr_ptr;
    logic [LANES-1:0]   grant;
    logic [LANE_W-1:0]  grant_idx;
    logic               any_grant;
    logic               accept;
    logic               recirc_fire;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter4 u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        case (grant_idx)
            2'd0:    sel_data = In0;
            2'd1:    sel_data = In1;
            2'd2:    sel_data = In2;
            default: sel_data = In3;
        endcase
    end

    assign accept      = !reset && (state != STALL) && (!validOut || dsReady) && any_grant;
    assign recirc_fire = (state == STALL) && !dsReady && (hold_cnt == CNT_W'(MAX_HOLD));
    assign pop         = accept ? grant : '0;
    assign busy        = validOut || (state == STALL);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            dataOut     <= '0;
            validOut    <= 1'b0;
            laneOut     <= '0;
            recircData  <= '0;
            recircValid <= 1'b0;
            hold_cnt    <= '0;
            rr_ptr      <= '0;
        end else begin
            recircValid <= 1'b0;
            if (accept) begin
                dataOut  <= sel_data;
                laneOut  <= grant_idx;
                validOut <= 1'b1;
                rr_ptr   <= grant_idx + LANE_W'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) state <= SEND;
                end
                SEND: begin
                    if (!dsReady) begin
                        state    <= STALL;
                        hold_cnt <= CNT_W'(1);
                    end else if (!accept) begin
                        state    <= IDLE;
                        validOut <= 1'b0;
                    end
                end
                STALL: begin
                    // Consumption takes precedence over the timeout.
                    if (dsReady) begin
                        state    <= IDLE;
                        validOut <= 1'b0;
                        hold_cnt <= '0;
                    end else if (recirc_fire) begin
                        recircData  <= dataOut;
                        recircValid <= 1'b1;
                        validOut    <= 1'b0;
                        hold_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STATS_EN
    logic [GCNT_W-1:0] grant_cnt [LANES];
    logic [RCNT_W-1:0] recirc_cnt;

    always_ff @(posedge clk) begin
        // NOTE: this small counter array is reset explicitly; it is flops, not a RAM.
        if (reset) begin
            for (int i = 0; i < LANES; i++) grant_cnt[i] <= '0;
            recirc_cnt <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (pop[i] && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + GCNT_W'(1);
            end
            if (recirc_fire && recirc_cnt != '1) recirc_cnt <= recirc_cnt + RCNT_W'(1);
        end
    end

    assign grantCnt0 = grant_cnt[0];
    assign grantCnt1 = grant_cnt[1];
    assign grantCnt2 = grant_cnt[2];
    assign grantCnt3 = grant_cnt[3];
    assign recircCnt = recirc_cnt;
`endif

endmodule

// File: tb/tb_recirc_lane_scheduler.sv
// Directed bench for recirc_lane_scheduler (MAX_HOLD=4); stats checks when STATS_EN is defined.
module tb_recirc_lane_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [7:0] In0, In1, In2, In3;
    logic       dsReady;
    logic [3:0] pop;
    logic [7:0] dataOut;
    logic       validOut;
    logic [1:0] laneOut;
    logic [7:0] recircData;
    logic       recircValid;
    logic       busy;
`ifdef STATS_EN
    logic [15:0] grantCnt0, grantCnt1, grantCnt2, grantCnt3;
    logic [7:0]  recircCnt;
`endif

    int tests_run;
    int tests_failed;

    recirc_lane_scheduler #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .In0         (In0),
        .In1         (In1),
        .In2         (In2),
        .In3         (In3),
        .dsReady     (dsReady),
        .pop         (pop),
        .dataOut     (dataOut),
        .validOut    (validOut),
        .laneOut     (laneOut),
        .recircData  (recircData),
        .recircValid (recircValid),
        .busy        (busy)
`ifdef STATS_EN
        ,
        .grantCnt0   (grantCnt0),
        .grantCnt1   (grantCnt1),
        .grantCnt2   (grantCnt2),
        .grantCnt3   (grantCnt3),
        .recircCnt   (recircCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        req = 4'b1111; dsReady = 1'b1;
        In0 = 8'h10; In1 = 8'h20; In2 = 8'h30; In3 = 8'h40;
        reset = 1'b1;
        step();
        step();
        tests_run++; if (dataOut !== 8'h00) begin tests_failed++; $display("FAIL reset_dataOut: got %h want 00", dataOut); end
        tests_run++; if (validOut !== 1'b0) begin tests_failed++; $display("FAIL reset_validOut: got %b want 0", validOut); end
        tests_run++; if (laneOut !== 2'd0) begin tests_failed++; $display("FAIL reset_laneOut: got %0d want 0", laneOut); end
        tests_run++; if (recircData !== 8'h00) begin tests_failed++; $display("FAIL reset_recircData: got %h want 00", recircData); end
        tests_run++; if (recircValid !== 1'b0) begin tests_failed++; $display("FAIL reset_recircValid: got %b want 0", recircValid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (pop !== 4'b0000) begin tests_failed++; $display("FAIL reset_pop: got %b want 0000", pop); end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_data [4];
        logic [3:0] exp_pop;
        exp_data = '{8'h10, 8'h20, 8'h30, 8'h40};
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_pop = 4'b0001 << (i % 4);
            tests_run++; if (pop !== exp_pop) begin tests_failed++; $display("FAIL rr_pop[%0d]: got %b want %b", i, pop, exp_pop); end
            step();
            tests_run++; if (validOut !== 1'b1) begin tests_failed++; $display("FAIL rr_valid[%0d]: got %b want 1", i, validOut); end
            tests_run++; if (laneOut !== 2'(i % 4)) begin tests_failed++; $display("FAIL rr_lane[%0d]: got %0d want %0d", i, laneOut, i % 4); end
            tests_run++; if (dataOut !== exp_data[i % 4]) begin tests_failed++; $display("FAIL rr_data[%0d]: got %h want %h", i, dataOut, exp_data[i % 4]); end
        end
    endtask

    task automatic test_single_lane;
        req = 4'b0100; In2 = 8'h55;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (pop !== 4'b0100) begin tests_failed++; $display("FAIL single_pop[%0d]: got %b want 0100", i, pop); end
            step();
            tests_run++; if (dataOut !== 8'h55 || laneOut !== 2'd2 || validOut !== 1'b1) begin
                tests_failed++; $display("FAIL single_out[%0d]: got data %h lane %0d valid %b want 55 2 1", i, dataOut, laneOut, validOut);
            end
        end
        req = 4'b0000;
        step();
        tests_run++; if (validOut !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_drain: got valid %b busy %b want 0 0", validOut, busy); end
    endtask

    task automatic test_recirc;
        do_reset();
        In0 = 8'hA5; req = 4'b0001; dsReady = 1'b1;
        #1;
        tests_run++; if (pop !== 4'b0001) begin tests_failed++; $display("FAIL recirc_pop0: got %b want 0001", pop); end
        step();
        req = 4'b1111; dsReady = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests_run++; if (dataOut !== 8'hA5 || validOut !== 1'b1 || recircValid !== 1'b0 || busy !== 1'b1) begin
                tests_failed++; $display("FAIL recirc_hold[%0d]: got data %h valid %b rv %b busy %b want A5 1 0 1", i, dataOut, validOut, recircValid, busy);
            end
            tests_run++; if (pop !== 4'b0000) begin tests_failed++; $display("FAIL recirc_stall_pop[%0d]: got %b want 0000", i, pop); end
        end
        req = 4'b0000;
        step();
        tests_run++; if (recircValid !== 1'b1 || recircData !== 8'hA5) begin tests_failed++; $display("FAIL recirc_strobe: got rv %b data %h want 1 A5", recircValid, recircData); end
        tests_run++; if (validOut !== 1'b0) begin tests_failed++; $display("FAIL recirc_valid_drop: got %b want 0", validOut); end
        step();
        tests_run++; if (recircValid !== 1'b0) begin tests_failed++; $display("FAIL recirc_one_cycle: got %b want 0", recircValid); end
        req = 4'b1111; dsReady = 1'b1;
        #1;
        tests_run++; if (pop !== 4'b0010) begin tests_failed++; $display("FAIL recirc_rr_next: got %b want 0010", pop); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_consume_at_limit;
        do_reset();
        In0 = 8'h77; req = 4'b0001; dsReady = 1'b1;
        step();
        req = 4'b0000; dsReady = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        req = 4'b0001; dsReady = 1'b1;
        #1;
        tests_run++; if (pop !== 4'b0000) begin tests_failed++; $display("FAIL limit_no_accept: got %b want 0000", pop); end
        step();
        tests_run++; if (recircValid !== 1'b0) begin tests_failed++; $display("FAIL limit_no_recirc: got %b want 0", recircValid); end
        tests_run++; if (validOut !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL limit_idle: got valid %b busy %b want 0 0", validOut, busy); end
        tests_run++; if (pop !== 4'b0001) begin tests_failed++; $display("FAIL limit_resume_pop: got %b want 0001", pop); end
        req = 4'b0000;
        step();
        tests_run++; if (recircValid !== 1'b0) begin tests_failed++; $display("FAIL limit_late_recirc: got %b want 0", recircValid); end
    endtask

    task automatic test_reset_in_stall;
        int pulses;
        do_reset();
        In2 = 8'h3C; req = 4'b0100; dsReady = 1'b1;
        step();
        req = 4'b0000; dsReady = 1'b0;
        step();
        step();
        tests_run++; if (dataOut !== 8'h3C || busy !== 1'b1) begin tests_failed++; $display("FAIL rst_stall_pre: got data %h busy %b want 3C 1", dataOut, busy); end
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (recircValid !== 1'b0) pulses++;
        end
        tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL rst_stall_pulse: got %0d pulses want 0", pulses); end
        tests_run++; if (dataOut !== 8'h00 || validOut !== 1'b0 || laneOut !== 2'd0 || recircData !== 8'h00 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL rst_stall_outs: got data %h valid %b lane %0d rdata %h busy %b want 00 0 0 00 0", dataOut, validOut, laneOut, recircData, busy);
        end
        reset = 1'b0; req = 4'b1111; dsReady = 1'b1;
        #1;
        tests_run++; if (pop !== 4'b0001) begin tests_failed++; $display("FAIL rst_stall_rr: got %b want 0001", pop); end
        step();
        tests_run++; if (laneOut !== 2'd0 || dataOut !== In0) begin tests_failed++; $display("FAIL rst_stall_first: got lane %0d data %h want 0 %h", laneOut, dataOut, In0); end
        req = 4'b0000;
        step();
    endtask

`ifdef STATS_EN
    task automatic test_stats;
        do_reset();
        In1 = 8'h11; req = 4'b0010; dsReady = 1'b1;
        for (int i = 0; i < 8; i++) step();
        req = 4'b0000; dsReady = 1'b0;
        for (int i = 0; i < 6; i++) step();
        tests_run++; if (grantCnt1 !== 16'd8) begin tests_failed++; $display("FAIL stats_grant1: got %0d want 8", grantCnt1); end
        tests_run++; if (recircCnt !== 8'd1) begin tests_failed++; $display("FAIL stats_recirc: got %0d want 1", recircCnt); end
        tests_run++; if (grantCnt0 !== 16'd0 || grantCnt2 !== 16'd0 || grantCnt3 !== 16'd0) begin
            tests_failed++; $display("FAIL stats_others: got %0d %0d %0d want 0 0 0", grantCnt0, grantCnt2, grantCnt3);
        end
        do_reset();
        tests_run++; if (grantCnt1 !== 16'd0 || recircCnt !== 8'd0) begin tests_failed++; $display("FAIL stats_clear: got %0d %0d want 0 0", grantCnt1, recircCnt); end
    endtask
`endif

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1; req = '0; dsReady = 1'b0;
        In0 = '0; In1 = '0; In2 = '0; In3 = '0;
        test_reset();
        test_round_robin();
        test_single_lane();
        test_recirc();
        test_consume_at_limit();
        test_reset_in_stall();
`ifdef STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
